vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Single-port framebuffer arbiter and double-buffer scheduler for the 800x600 @ 60 Hz, 40 MHz display path. It shares one synchronous single-port pixel RAM between two requesters. The display read pipeline always has priority. A drawing engine writes in the cycles the display leaves free. The block also owns front/back buffer selection, swapping buffers only at the start of vertical blanking so a frame never tears.

## Interface
Parameters:
- ADDR_W, 19, pixel address width within one buffer (800*600 = 480000 < 2^19)
- DATA_W, 12, pixel width (RGB 4:4:4)

Ports:
- clk  in  1  40 MHz pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blanking flag from the timing generator
- rd_req  in  1  display read request; one pixel per cycle
- rd_addr  in  ADDR_W  display pixel address
- rd_data  out  DATA_W  read pixel; equals mem_rdata
- rd_valid  out  1  rd_data valid
- wr_req  in  1  writer request (valid)
- wr_addr  in  ADDR_W  writer pixel address
- wr_data  in  DATA_W  writer pixel
- wr_ready  out  1  write accepted this cycle when wr_req && wr_ready
- swap_req  in  1  single-cycle request to swap front/back at next vblank start
- swap_pending  out  1  swap requested, not yet performed
- swap_done  out  1  one-cycle pulse when the swap takes effect
- front_buf  out  1  buffer currently displayed
- mem_en  out  1  RAM enable, registered
- mem_we  out  1  RAM write enable, registered
- mem_addr  out  ADDR_W+1  {buffer bit, pixel address}, registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_en

## Operation
- Buffer mapping:
  - Reads target {front_buf, rd_addr}.
  - Writes target {~front_buf, wr_addr}.
  - The buffer bit is captured at issue, so in-flight reads are unaffected by a swap.
- Per-cycle arbitration, evaluated combinationally, registered onto the mem_* outputs:
  - READ if rd_req.
  - Otherwise WRITE if wr_req && !swap_pending.
  - Otherwise IDLE.
- wr_ready = !rd_req && !swap_pending (combinational). It does not depend on wr_req.
- Writer starvation during active video is legal. The writer is guaranteed service during blanking, when the display pipeline does not assert rd_req.
- rd_req asserted during blanking is still served; there is no vblnk gating of reads.
- Swap FSM:
  - States: IDLE and PENDING.
  - IDLE -> PENDING on swap_req.
  - PENDING -> IDLE at the vblnk rising edge (vblnk && !vblnk_q, with vblnk_q a registered copy).
  - On that edge: front_buf toggles and swap_done pulses.
- Same-cycle boundary: swap_req coinciding with the vblnk rising edge swaps at that edge. It does not wait for the next frame.
- Ignored requests:
  - swap_req while PENDING is ignored; no double toggle.
  - swap_req in a cycle where the FSM returns to IDLE is also ignored.
- While PENDING, writes stall because the back buffer is about to become visible. Writes resume into the new back buffer on the cycle after swap_done.

## Timing
- Reset values (all outputs and registers): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, swap_done=0, swap_pending=0, front_buf=0, FSM=IDLE, vblnk_q=0.
- Reset mid-operation:
  - In-flight rd_valid is dropped.
  - A pending swap is cancelled.
  - front_buf returns to 0.
- Read: rd_req in cycle N, then mem_en=1, mem_we=0 in N+1, then rd_valid=1 with rd_data=mem_rdata in N+2. Latency is 2 cycles, throughput 1/cycle.
- Write: accepted in cycle N, then mem_en=1, mem_we=1, mem_addr, mem_wdata in N+1. The writer may change wr_addr/wr_data in N+1.
- Swap: vblnk rises in cycle E (vblnk_q still 0), then front_buf toggles, swap_done=1 and swap_pending=0 in E+1. wr_ready may assert from E+1.
- The first read after the swap that uses the new front is the one issued in E+1.

## Test plan
- Reset, then rd_req with rd_addr=0x00010 at cycle N, mem_rdata=0xABC at N+2 -> mem_addr=0x00010 (buffer 0) at N+1; rd_valid=1, rd_data=0xABC at N+2.
- Concurrent rd_req and wr_req (wr_addr=0x00020, wr_data=0x123) for 3 cycles, then rd_req low -> wr_ready=0 for 3 cycles; then wr_ready=1; mem_we=1, mem_addr=0x80020, mem_wdata=0x123 one cycle later.
- swap_req pulse during active video, then vblnk rises 100 cycles later -> swap_pending=1 and wr_ready=0 throughout; front_buf 0->1 and swap_done pulse one cycle after the edge; next write goes to mem_addr bit ADDR_W=0.
- Edge and overlap cases:
  - swap_req in the same cycle as the vblnk rising edge -> swap at that edge.
  - Second swap_req while pending -> exactly one toggle.
- rst asserted one cycle after a read issue and with a swap pending -> rd_valid stays 0, swap_pending=0, front_buf=0 the next cycle.
- Full frame at 1056x628 timing: reads every active pixel plus continuous wr_req -> every accepted write falls in a non-read cycle; all read data is returned in order with 2-cycle latency.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter with tear-free front/back buffer swap
module vga_fb_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblnk,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_buf,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;
    logic [0:0]        r_state;
    logic              r_vblnk_q;
    logic              r_front;
    logic              r_swap_done;
    logic              r_rd_p;
    logic              r_rd_valid;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W:0]   r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_edge;
    logic              w_pend;
    logic              w_swap;
    logic              w_rd;
    logic              w_wr;
    // display reads win; writes only in free cycles while no swap is waiting
    always_comb begin
        w_edge = vblnk && !r_vblnk_q;
        w_pend = r_state == S_PEND;
        w_swap = w_edge && (w_pend || swap_req);
        w_rd   = rd_req;
        w_wr   = !rd_req && wr_req && !w_pend;
    end
    // swap scheduler: a request waits for the next vblank rising edge, or swaps at once if it lands on it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vblnk_q   <= 1'b0;
            r_front     <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_vblnk_q   <= vblnk;
            r_swap_done <= w_swap;
            r_front     <= r_front ^ w_swap;
            r_state     <= (!w_edge && (w_pend || swap_req)) ? S_PEND : S_IDLE;
        end
    end
    // registered RAM command; buffer bit is frozen at issue so in-flight reads ignore a swap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_p      <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_mem_en   <= w_rd || w_wr;
            r_mem_we   <= w_wr;
            r_rd_p     <= w_rd;
            r_rd_valid <= r_rd_p;
            if (w_rd) begin
                r_mem_addr <= {r_front, rd_addr};
            end else if (w_wr) begin
                r_mem_addr  <= {~r_front, wr_addr};
                r_mem_wdata <= wr_data;
            end
        end
    end
    assign wr_ready     = !rd_req && !w_pend;
    assign rd_data      = mem_rdata;
    assign rd_valid     = r_rd_valid;
    assign swap_pending = w_pend;
    assign swap_done    = r_swap_done;
    assign front_buf    = r_front;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for the framebuffer arbiter and buffer swap
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b0;
    logic        rd_req = 1'b0;
    logic [18:0] rd_addr = '0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_ready;
    logic        swap_req = 1'b0;
    logic        swap_pending;
    logic        swap_done;
    logic        front_buf;
    logic        mem_en;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    logic m_front = 1'b0;
    logic m_pend = 1'b0;
    logic m_done = 1'b0;
    logic m_vq = 1'b0;
    logic [19:0] q_ra[$];
    logic [11:0] q_rd[$];
    int          q_rc[$];
    logic [31:0] q_w[$];

    vga_fb_arbiter #(.ADDR_W(19), .DATA_W(12)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done), .front_buf(front_buf),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] hsh(input logic [19:0] a);
        return a[11:0] ^ {a[19:12], 4'h5} ^ 12'h3C7;
    endfunction

    // RAM stand-in: read data depends on the full address, including the buffer bit
    always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= hsh(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc_n);
        end
    endtask

    task automatic step(input logic rd, input logic [18:0] ra, input logic wr, input logic [18:0] wa,
                        input logic [11:0] wd, input logic sw, input logic vb, input logic rs);
        logic e;
        logic [31:0] x;
        rd_req = rd; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
        swap_req = sw; vblnk = vb; rst = rs;
        @(negedge clk);
        chk("wr_ready", wr_ready, !rd && !m_pend);
        if (rs) begin
            q_ra.delete(); q_rd.delete(); q_rc.delete(); q_w.delete();
            m_front = 0; m_pend = 0; m_done = 0; m_vq = 0;
        end else begin
            if (rd) begin
                q_ra.push_back({m_front, ra});
                q_rd.push_back(hsh({m_front, ra}));
                q_rc.push_back(cyc_n);
            end else if (wr && !m_pend) begin
                q_w.push_back({~m_front, wa, wd});
            end
            e = vb && !m_vq;
            m_done = 0;
            if (m_pend) begin
                if (e) begin m_pend = 0; m_front = ~m_front; m_done = 1; end
            end else if (sw) begin
                if (e) begin m_front = ~m_front; m_done = 1; end
                else m_pend = 1;
            end
            m_vq = vb;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        chk("front_buf", front_buf, m_front);
        chk("swap_pending", swap_pending, m_pend);
        chk("swap_done", swap_done, m_done);
        if (mem_en && mem_we) begin
            if (q_w.size() == 0) chk("wr_unexpected", 1, 0);
            else begin x = q_w.pop_front(); chk("wr_cmd", {mem_addr, mem_wdata}, x); end
        end else if (mem_en) begin
            if (q_ra.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", mem_addr, q_ra.pop_front());
        end
        if (q_w.size() != 0) begin chk("wr_missing", 0, 1); q_w.delete(); end
        if (q_ra.size() != 0) begin chk("rd_missing", 0, 1); q_ra.delete(); end
        if (rd_valid) begin
            if (q_rd.size() == 0) chk("rd_valid_unexpected", 1, 0);
            else begin
                chk("rd_data", rd_data, q_rd.pop_front());
                chk("rd_latency", cyc_n - q_rc.pop_front(), 2);
            end
        end else if (q_rc.size() != 0 && cyc_n - q_rc[0] >= 2) begin
            chk("rd_valid", 0, 1);
            void'(q_rd.pop_front());
            void'(q_rc.pop_front());
        end
    endtask

    task automatic idle(input int n, input logic vb);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, vb, 0);
    endtask

    initial begin
        logic [18:0] wa;
        // reset and reset state
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rd_valid", rd_valid, 0);
        // single read from buffer 0
        step(1, 19'h00010, 0, 0, 0, 0, 0, 0);
        chk("rd0_addr", mem_addr, 20'h00010);
        idle(3, 0);
        // read blocks the writer for three cycles, then the write lands in buffer 1
        for (int i = 0; i < 3; i++) step(1, 19'h100 + 19'(i), 1, 19'h00020, 12'h123, 0, 0, 0);
        step(0, 0, 1, 19'h00020, 12'h123, 0, 0, 0);
        chk("wr0_cmd", {mem_addr, mem_wdata}, 32'h80020123);
        idle(3, 0);
        // swap requested in active video, vblank 100 cycles later
        step(0, 0, 1, 19'h00030, 12'h321, 1, 0, 0);
        for (int i = 0; i < 100; i++) step(i[0], 19'(i), 1, 19'h00040, 12'h456, 0, 0, 0);
        step(0, 0, 1, 19'h00050, 12'h789, 0, 1, 0);
        chk("swap1_done", swap_done, 1);
        chk("swap1_front", front_buf, 1);
        step(0, 0, 1, 19'h00051, 12'h78A, 0, 1, 0);
        chk("swap1_wr_buf", mem_addr[19], 0);
        for (int i = 0; i < 4; i++) step(1, 19'h200 + 19'(i), 1, 19'h00052, 12'h78B, 0, 1, 0);
        idle(5, 0);
        // swap request coinciding with the vblank rising edge
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("swap2_front", front_buf, 0);
        idle(3, 1);
        idle(3, 0);
        // repeated requests while pending, and a request on the swap edge itself
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(5, 0);
        step(0, 0, 1, 19'h00060, 12'hAAA, 1, 0, 0);
        idle(5, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        idle(3, 1);
        idle(3, 0);
        chk("double_front", front_buf, 1);
        // reset right after a read issue with a swap pending
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(3, 0);
        step(1, 19'h00070, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_rd_valid", rd_valid, 0);
        chk("rst_mid_pending", swap_pending, 0);
        chk("rst_mid_front", front_buf, 0);
        idle(3, 0);
        // slice of a 1056x628 frame across the start of vblank, with a continuous writer
        wa = 0;
        for (int y = 596; y < 604; y++) begin
            for (int x = 0; x < 1056; x++) begin
                logic act;
                act = (x < 800) && (y < 600);
                if (!act && !m_pend) begin
                    step(0, 0, 1, wa, wa[11:0] ^ 12'hF0F, (y == 597 && x == 0), y >= 600, 0);
                    wa++;
                end else begin
                    step(act, 19'(y * 800 + x), 1, wa, wa[11:0] ^ 12'hF0F, (y == 597 && x == 0), y >= 600, 0);
                end
            end
        end
        chk("frame_front", front_buf, 1);
        idle(3, 0);
        chk("end_rd_queue", q_rd.size(), 0);
        chk("end_wr_queue", q_w.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
